arbitro_recepcion: RTL and testbench
====================================

# arbitro_recepcion

Return-path arbiter: drains the two downstream data FIFOs (D0, D1) and steers each 6-bit word into one of the two virtual-channel FIFOs (VC0, VC1) according to its class bit. It sits between the D0/D1 FIFO outputs and the VC0/VC1 FIFO inputs. It is the reverse of the VC-to-D routing arbiter. One word is popped per cycle at most, using round-robin between sources and conservative pause-based flow control.

## Interface
Parameters:
- WIDTH, 6, word width; bit WIDTH-1 is the class bit.
- CNT_W, 8, width of the per-VC forwarded-word counters.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- D0_in  input  WIDTH  D0 FIFO read data; valid the cycle after D0_pop.
- D1_in  input  WIDTH  D1 FIFO read data; valid the cycle after D1_pop.
- D0_empty  input  1  D0 FIFO empty.
- D1_empty  input  1  D1 FIFO empty.
- VC0_pause  input  1  VC0 FIFO almost-full; threshold leaves at least 2 free entries.
- VC1_pause  input  1  VC1 FIFO almost-full; same threshold.
- D0_pop  output  1  pop D0; combinational from state and inputs.
- D1_pop  output  1  pop D1.
- VC0_push  output  1  registered push into VC0.
- VC0_out  output  WIDTH  registered data to VC0.
- VC1_push  output  1  registered push into VC1.
- VC1_out  output  WIDTH  registered data to VC1.
- VC0_count  output  CNT_W  words pushed into VC0 since reset; wraps.
- VC1_count  output  CNT_W  words pushed into VC1 since reset; wraps.
- idle  output  1  high when no word is in flight and no pop is issued this cycle.

## Operation
**Eligibility**
- Dn is eligible when !Dn_empty && !VC0_pause && !VC1_pause && !reset.
- Both pauses gate the pop because the destination is unknown until the word is read.

**Arbitration**
- Round-robin register `last`, with reset value 1 so that D0 wins the first tie.
- If both sources are eligible, pop the one != last.
- If only one source is eligible, pop it.
- On every pop, `last` is set to the popped source.
- D0_pop and D1_pop are never high in the same cycle.

**Pipeline**
- Stage 1, registered: `s1_valid <= pop issued`, `s1_src <= source popped`.
- Stage 2, registered on s1_valid: word = s1_src ? D1_in : D0_in.
  - Class bit = 0: VC0_push <= 1, VC0_out <= word.
  - Class bit = 1: VC1_push <= 1, VC1_out <= word.
  - The other push is 0. The word is forwarded unmodified.
- When a push is 0, the matching VCn_out holds its last value.
- VCn_count increments by 1 on the same edge that sets VCn_push. It wraps 2^CNT_W-1 -> 0.
- idle = !s1_valid && !VC0_push && !VC1_push && !D0_pop && !D1_pop.

**Pause behaviour**
- Pause only blocks new pops.
- Words already in stage 1 or stage 2 always complete their push. The 2-entry pause margin guarantees they are absorbed.

**Reset**
- Every cycle with reset high: all pops are forced 0.
- On the edge: s1_valid=0, last=1.
- Outputs after reset: VC0_push=VC1_push=0, VC0_out=VC1_out=0, VC0_count=VC1_count=0, idle=1.
- Reset mid-operation drops in-flight words silently; the source FIFOs have already consumed them.

## Timing
- Pop issued in cycle N. Source data valid in N+1. VCn_push and VCn_out valid in N+2. Latency is 2 cycles.
- Throughput: 1 word/cycle sustained, while at least one source is non-empty and both pauses are low.
- Pause or empty rising in cycle N blocks the pop in cycle N itself; these are combinational paths to the pops.
- Back-to-back pops to different classes give VC0_push and VC1_push in consecutive cycles, never both in one cycle.
- A count value is visible in the same cycle as the push it counts.

## Test plan
- **Reset:** hold reset 3 cycles with D0_empty=0 and D1_empty=0 -> D0_pop=D1_pop=0 throughout, both pushes 0, both counts 0, idle=1.
- **Single word:** D0 holds 0x25, pop in cycle N -> VC1_push=1 with VC1_out=0x25 in N+2, VC1_count=1, VC0_push=0. Then D0 holds 0x05 -> VC0_out=0x05 two cycles after its pop.
- **Round-robin:** both sources non-empty for 6 cycles -> pop order D0, D1, D0, D1, D0, D1 with no idle cycle; pushes follow 2 cycles later in the same order.
- **Pause:** assert VC0_pause for 4 cycles mid-stream -> no pops during those cycles; the 2 in-flight words still push; popping resumes the cycle pause drops, with the round-robin order preserved.
- **Counter wrap:** push 256 class-0 words -> VC0_count goes 255 -> 0 on the 256th push; VC1_count stays unchanged.
- **Reset mid-stream:** reset in cycle N+1 after a pop in N -> no push in N+2, counts=0, idle=1; the first pop after reset releases is from D0.

Source files
------------

// File: rtl/arbitro_recepcion_if.sv
// Signal bundle between the D0/D1 source FIFOs, the return-path arbiter and
// the VC0/VC1 destination FIFOs. slave is the arbiter view, master the FIFO side.
interface arbitro_recepcion_if #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] D0_in;
    logic [WIDTH-1:0] D1_in;
    logic             D0_empty;
    logic             D1_empty;
    logic             VC0_pause;
    logic             VC1_pause;
    logic             D0_pop;
    logic             D1_pop;
    logic             VC0_push;
    logic [WIDTH-1:0] VC0_out;
    logic             VC1_push;
    logic [WIDTH-1:0] VC1_out;
    logic [CNT_W-1:0] VC0_count;
    logic [CNT_W-1:0] VC1_count;
    logic             idle;

    modport slave (
        input  D0_in, D1_in, D0_empty, D1_empty, VC0_pause, VC1_pause,
        output D0_pop, D1_pop, VC0_push, VC0_out, VC1_push, VC1_out,
               VC0_count, VC1_count, idle
    );

    modport master (
        output D0_in, D1_in, D0_empty, D1_empty, VC0_pause, VC1_pause,
        input  D0_pop, D1_pop, VC0_push, VC0_out, VC1_push, VC1_out,
               VC0_count, VC1_count, idle
    );
endinterface

// File: rtl/arbitro_recepcion.sv
// Return-path arbiter: round-robin drain of D0/D1 into VC0/VC1 by class bit,
// two-cycle pipeline (pop -> source data -> registered push).
module arbitro_recepcion #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8
) (
    input logic                  clk,
    input logic                  reset,
    arbitro_recepcion_if.slave   bus
);
    // Handshake: a pop fires only when its source is non-empty and neither
    // sink is paused; pushes are unconditional, the pause margin absorbs the
    // (at most two) words already in flight.
    typedef enum logic {
        SRC_D0 = 1'b0,
        SRC_D1 = 1'b1
    } src_e;

    src_e             last;
    src_e             s1_src;
    logic             s1_valid;
    logic             elig0;
    logic             elig1;
    logic             pop0;
    logic             pop1;
    logic [WIDTH-1:0] word;
    logic             vc0_push_q;
    logic             vc1_push_q;
    logic [WIDTH-1:0] vc0_out_q;
    logic [WIDTH-1:0] vc1_out_q;
    logic [CNT_W-1:0] vc0_count_q;
    logic [CNT_W-1:0] vc1_count_q;

    // Both pauses gate every pop: the destination is unknown until read.
    assign elig0 = !bus.D0_empty && !bus.VC0_pause && !bus.VC1_pause && !reset;
    assign elig1 = !bus.D1_empty && !bus.VC0_pause && !bus.VC1_pause && !reset;

    always_comb begin
        pop0 = 1'b0;
        pop1 = 1'b0;
        if (elig0 && elig1) begin
            if (last == SRC_D1) pop0 = 1'b1;
            else                pop1 = 1'b1;
        end else if (elig0) begin
            pop0 = 1'b1;
        end else if (elig1) begin
            pop1 = 1'b1;
        end
    end

    assign word = (s1_src == SRC_D1) ? bus.D1_in : bus.D0_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            last        <= SRC_D1;
            s1_valid    <= 1'b0;
            s1_src      <= SRC_D0;
            vc0_push_q  <= 1'b0;
            vc1_push_q  <= 1'b0;
            vc0_out_q   <= '0;
            vc1_out_q   <= '0;
            vc0_count_q <= '0;
            vc1_count_q <= '0;
        end else begin
            s1_valid   <= pop0 || pop1;
            vc0_push_q <= 1'b0;
            vc1_push_q <= 1'b0;
            if (pop0 || pop1) begin
                s1_src <= src_e'(pop1);
                last   <= src_e'(pop1);
            end
            if (s1_valid) begin
                if (word[WIDTH-1]) begin
                    vc1_push_q  <= 1'b1;
                    vc1_out_q   <= word;
                    vc1_count_q <= vc1_count_q + CNT_W'(1);
                end else begin
                    vc0_push_q  <= 1'b1;
                    vc0_out_q   <= word;
                    vc0_count_q <= vc0_count_q + CNT_W'(1);
                end
            end
        end
    end

    assign bus.D0_pop    = pop0;
    assign bus.D1_pop    = pop1;
    assign bus.VC0_push  = vc0_push_q;
    assign bus.VC1_push  = vc1_push_q;
    assign bus.VC0_out   = vc0_out_q;
    assign bus.VC1_out   = vc1_out_q;
    assign bus.VC0_count = vc0_count_q;
    assign bus.VC1_count = vc1_count_q;
    assign bus.idle      = !s1_valid && !vc0_push_q && !vc1_push_q && !pop0 && !pop1;
endmodule

// File: tb/tb_arbitro_recepcion.sv
// Directed bench for arbitro_recepcion: FIFO source model, push scoreboard
// with expected queue, per-cycle pop/idle/count checks.
module tb_arbitro_recepcion;
    localparam int WIDTH = 6;
    localparam int CNT_W = 8;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    arbitro_recepcion_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    arbitro_recepcion #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fails  = 0;

    logic [WIDTH-1:0] d0_q[$];
    logic [WIDTH-1:0] d1_q[$];
    logic [WIDTH:0]   exp_q[$];   // {vc, word}

    logic             s_pop0, s_pop1, s_push0, s_push1, s_idle;
    logic [WIDTH-1:0] s_out0, s_out1;
    logic [CNT_W-1:0] s_cnt0, s_cnt1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic update_empties();
        bus.D0_empty = (d0_q.size() == 0);
        bus.D1_empty = (d1_q.size() == 0);
    endtask

    task automatic load(input int src, input logic [WIDTH-1:0] w);
        if (src == 0) d0_q.push_back(w);
        else          d1_q.push_back(w);
        update_empties();
    endtask

    task automatic exp_push(input logic vc, input logic [WIDTH-1:0] w);
        exp_q.push_back({vc, w});
    endtask

    // Completes the current cycle: samples at negedge, scores pushes, then
    // advances the FIFO model just after the rising edge.
    task automatic tick();
        logic [31:0] want;
        @(negedge clk);
        s_pop0  = bus.D0_pop;
        s_pop1  = bus.D1_pop;
        s_push0 = bus.VC0_push;
        s_push1 = bus.VC1_push;
        s_out0  = bus.VC0_out;
        s_out1  = bus.VC1_out;
        s_cnt0  = bus.VC0_count;
        s_cnt1  = bus.VC1_count;
        s_idle  = bus.idle;
        check_eq("pop_onehot", 32'(s_pop0 && s_pop1), 32'd0);
        if (s_push0 || s_push1) begin
            check_eq("push_onehot", 32'(s_push0 && s_push1), 32'd0);
            if (exp_q.size() > 0) want = 32'(exp_q.pop_front());
            else                  want = 32'hFFFF_FFFF;
            check_eq("push_data", s_push1 ? 32'({1'b1, s_out1}) : 32'({1'b0, s_out0}), want);
        end
        @(posedge clk);
        #1;
        if (s_pop0 && d0_q.size() > 0) bus.D0_in = d0_q.pop_front();
        if (s_pop1 && d1_q.size() > 0) bus.D1_in = d1_q.pop_front();
        update_empties();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            tick();
            check_eq("rst_pops", {30'd0, s_pop1, s_pop0}, 32'd0);
        end
        reset = 1'b0;
    endtask

    // ---------------- stimulus tables ----------------
    logic [1:0] rr_pop    [6]  = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
    logic [1:0] pz_pop    [10] = '{2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2};
    logic       pz_pause  [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        reset         = 1'b1;
        bus.D0_in     = '0;
        bus.D1_in     = '0;
        bus.VC0_pause = 1'b0;
        bus.VC1_pause = 1'b0;
        load(0, 6'h3F);
        load(1, 6'h3F);
        @(posedge clk);
        #1;

        // Reset held with both sources non-empty
        repeat (3) begin
            tick();
            check_eq("rst_pops", {30'd0, s_pop1, s_pop0}, 32'd0);
            check_eq("rst_push", {30'd0, s_push1, s_push0}, 32'd0);
            check_eq("rst_cnt", {16'd0, s_cnt1, s_cnt0}, 32'd0);
            check_eq("rst_out", {20'd0, s_out1, s_out0}, 32'd0);
            check_eq("rst_idle", 32'(s_idle), 32'd1);
        end
        d0_q.delete();
        d1_q.delete();
        update_empties();
        reset = 1'b0;

        // Single word 0x25 (class 1) then 0x05 (class 0)
        load(0, 6'h25);
        exp_push(1'b1, 6'h25);
        tick();
        check_eq("sw_pop_n", {30'd0, s_pop1, s_pop0}, 32'd1);
        tick();
        check_eq("sw_pop_n1", {30'd0, s_pop1, s_pop0}, 32'd0);
        check_eq("sw_idle_n1", 32'(s_idle), 32'd0);
        tick();
        check_eq("sw_vc1_push", 32'(s_push1), 32'd1);
        check_eq("sw_vc1_out", 32'(s_out1), 32'h25);
        check_eq("sw_vc0_push", 32'(s_push0), 32'd0);
        check_eq("sw_vc1_cnt", 32'(s_cnt1), 32'd1);
        tick();
        check_eq("sw_idle_after", 32'(s_idle), 32'd1);
        load(0, 6'h05);
        exp_push(1'b0, 6'h05);
        tick();
        check_eq("sw2_pop", {30'd0, s_pop1, s_pop0}, 32'd1);
        tick();
        tick();
        check_eq("sw2_vc0_push", 32'(s_push0), 32'd1);
        check_eq("sw2_vc0_out", 32'(s_out0), 32'h05);
        check_eq("sw2_vc0_cnt", 32'(s_cnt0), 32'd1);
        tick();
        check_eq("sw_sb_drain", 32'(exp_q.size()), 32'd0);

        // Round-robin, both sources loaded, fresh reset so D0 wins first
        do_reset(1);
        load(0, 6'h01); load(0, 6'h22); load(0, 6'h03);
        load(1, 6'h31); load(1, 6'h12); load(1, 6'h33);
        exp_push(1'b0, 6'h01); exp_push(1'b1, 6'h31); exp_push(1'b1, 6'h22);
        exp_push(1'b0, 6'h12); exp_push(1'b0, 6'h03); exp_push(1'b1, 6'h33);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq($sformatf("rr_pop%0d", i), {30'd0, s_pop1, s_pop0}, 32'(rr_pop[i]));
            check_eq($sformatf("rr_idle%0d", i), 32'(s_idle), 32'd0);
        end
        tick();
        tick();
        check_eq("rr_sb_drain", 32'(exp_q.size()), 32'd0);
        check_eq("rr_cnt0", 32'(s_cnt0), 32'd3);
        check_eq("rr_cnt1", 32'(s_cnt1), 32'd3);

        // VC0 pause for 4 cycles mid-stream
        load(0, 6'h04); load(0, 6'h05); load(0, 6'h26);
        load(1, 6'h14); load(1, 6'h27); load(1, 6'h08);
        exp_push(1'b0, 6'h04); exp_push(1'b0, 6'h14); exp_push(1'b0, 6'h05);
        exp_push(1'b1, 6'h27); exp_push(1'b1, 6'h26); exp_push(1'b0, 6'h08);
        for (int i = 0; i < 10; i++) begin
            bus.VC0_pause = pz_pause[i];
            tick();
            check_eq($sformatf("pz_pop%0d", i), {30'd0, s_pop1, s_pop0}, 32'(pz_pop[i]));
            if (i == 2 || i == 3) check_eq($sformatf("pz_inflight%0d", i), 32'(s_push0), 32'd1);
        end
        bus.VC0_pause = 1'b0;
        tick();
        tick();
        check_eq("pz_sb_drain", 32'(exp_q.size()), 32'd0);
        check_eq("pz_cnt0", 32'(s_cnt0), 32'd7);
        check_eq("pz_cnt1", 32'(s_cnt1), 32'd5);

        // VC0 counter wrap over 256 class-0 words
        do_reset(1);
        for (int i = 0; i < 256; i++) begin
            load(0, 6'(i % 32));
            exp_push(1'b0, 6'(i % 32));
        end
        tick();
        check_eq("wr_pop_first", {30'd0, s_pop1, s_pop0}, 32'd1);
        tick();
        for (int k = 0; k < 256; k++) begin
            tick();
            if (k == 0)   check_eq("wr_cnt_first", 32'(s_cnt0), 32'd1);
            if (k == 254) check_eq("wr_cnt_255", 32'(s_cnt0), 32'd255);
            if (k == 255) begin
                check_eq("wr_cnt_wrap", 32'(s_cnt0), 32'd0);
                check_eq("wr_cnt1_hold", 32'(s_cnt1), 32'd0);
            end
        end
        tick();
        check_eq("wr_sb_drain", 32'(exp_q.size()), 32'd0);

        // Reset while a word is in flight
        load(0, 6'h0A);
        load(1, 6'h2B); load(1, 6'h2C);
        tick();
        check_eq("mr_pop_n", {30'd0, s_pop1, s_pop0}, 32'd2);
        reset = 1'b1;
        tick();
        check_eq("mr_pop_n1", {30'd0, s_pop1, s_pop0}, 32'd0);
        tick();
        check_eq("mr_push_n2", {30'd0, s_push1, s_push0}, 32'd0);
        check_eq("mr_cnt_n2", {16'd0, s_cnt1, s_cnt0}, 32'd0);
        check_eq("mr_idle_n2", 32'(s_idle), 32'd1);
        reset = 1'b0;
        exp_push(1'b0, 6'h0A);
        exp_push(1'b1, 6'h2C);
        tick();
        check_eq("mr_first_pop", {30'd0, s_pop1, s_pop0}, 32'd1);
        tick();
        check_eq("mr_second_pop", {30'd0, s_pop1, s_pop0}, 32'd2);
        tick();
        tick();
        tick();
        check_eq("mr_sb_drain", 32'(exp_q.size()), 32'd0);
        check_eq("mr_cnt0", 32'(s_cnt0), 32'd1);
        check_eq("mr_cnt1", 32'(s_cnt1), 32'd1);
        check_eq("mr_idle_end", 32'(s_idle), 32'd1);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
